crc16_frame_sched: RTL and testbench
====================================

Name: crc16_frame_sched

Overview:
- Shares one bit-serial CRC-16 engine between two 34-bit word requesters, using round-robin arbitration.
- Sequences each granted word through the engine, one bit per clock, MSB first.
- Emits a 50-bit codeword {data, crc} on a valid/ready output port.
- Sits between the word sources and the serial framer. It replaces free-running, count-driven CRC sequencing with an explicit handshake-controlled engine.

Parameters:
- DW, 34, data word width in bits.
- CW, 16, CRC width in bits; fixed at 16.
- POLY, 16'hBAAD, generator polynomial without the x^16 term (bit i = coefficient of x^i).
- INIT, 16'h0000, CRC register value loaded at the start of each word.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  DW  requester 0 word.
- req0_ready  out  1  requester 0 word accepted on this edge when valid is also high.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  DW  requester 1 word.
- req1_ready  out  1  requester 1 word accepted on this edge when valid is also high.
- out_valid  out  1  codeword available.
- out_data  out  DW+CW  {word, crc}.
- out_src  out  1  index of the requester that supplied out_data.
- out_ready  in  1  downstream accepts the codeword.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, crc=INIT, bit counter=0, shift register=0.
  - out_valid=0, out_data=0, out_src=0, busy=0.
  - last-served pointer=1, so requester 0 wins the first contention.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - reqN_ready is combinational and asserted only in IDLE, only for the granted requester.
  - Grant rule: if only one reqN_valid is high, that requester is granted. If both are high, the requester != last-served pointer is granted. If neither is high, no ready is asserted.
  - On the accept edge (valid & ready):
    - latch the word into the shift register and into the held word;
    - set out_src to the granted index and the pointer to the granted index;
    - set crc=INIT, counter=0, and go to SHIFT.
- SHIFT: each edge processes one bit.
  - fb = shreg[DW-1] ^ crc[15].
  - crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0).
  - Shift the register left by one and increment the counter.
  - On the edge where the counter reaches DW-1 (i.e. the DW-th bit), go to DONE.
  - Result equals M(x)*x^16 mod G(x) when INIT=0.
- DONE:
  - out_valid=1 and out_data={held word, crc}; both stay stable until out_ready is seen.
  - On the out_valid & out_ready edge: out_valid=0, go to IDLE.
  - A new word cannot be accepted on that same edge; the earliest accept is the next edge.
- Latency: accept edge E0; out_valid is high after edge E0+DW (34). Throughput is one word per DW+2 cycles with out_ready tied high.
- Input rules:
  - Inputs are ignored outside IDLE, and reqN_ready=0 there.
  - Requesters must hold valid and data until ready. A requester dropping valid before grant is legal and loses nothing.
- out_ready held low stalls the block in DONE indefinitely. crc, out_data and out_src do not change.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to reset values and the in-flight word is discarded. The first IDLE cycle after reset release grants normally.
- No word is ever accepted twice, and no codeword is ever dropped.

Test Plan:
- Reset, then req0_valid with req0_data=34'h0 -> req0_ready in the same cycle; out_valid after 34 edges; out_data=50'h0, out_src=0.
- req1 only, data 34'h1 -> out_data=50'h1BAAD, out_src=1, busy high from E0+1 until the output handshake.
- req0 data 34'h2 -> out_data=50'h2CFF7. Hold out_ready=0 for 10 cycles -> out_valid and out_data stable and busy=1; release -> IDLE next edge.
- Both requesters continuously valid, out_ready=1 -> grants alternate 0,1,0,1. Each codeword's out_src matches its source, and the accept-to-accept spacing is 36 cycles.
- Assert reset at bit 20 of SHIFT -> out_valid=0 and busy=0 immediately, with no codeword emitted. After release, a word 34'h1 -> 50'h1BAAD.
- Random words over 1000 frames with random out_ready backpressure -> every out_data low 16 bits matches a reference CRC model; sequence and count are preserved per requester.

Source files
------------

// File: rtl/crc16_frame_sched.sv
// Shares one bit-serial CRC-16 engine between two word requesters (round-robin).
// Latency: out_valid rises DW edges after the accept edge; one word per DW+2 cycles.
// Backpressure: out_ready low holds the codeword in DONE; requesters see ready=0 until IDLE.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   req0_*, req1_*         requester valid/ready/data (ready combinational, IDLE only)
//   out_valid/out_ready    codeword handshake; out_data = {word, crc}, out_src = requester
//   busy                   high whenever the engine is not IDLE
module crc16_frame_sched #(
  parameter int            DW   = 34,
  parameter int            CW   = 16,
  parameter logic [CW-1:0] POLY = 16'hBAAD,
  parameter logic [CW-1:0] INIT = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [DW-1:0]    req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [DW-1:0]    req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [DW+CW-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CNTW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   shreg;
  logic [DW-1:0]   held;
  logic [CW-1:0]   crc;
  logic [CNTW-1:0] cnt;
  logic            last;     // index of the requester served most recently
  logic            src_q;

  logic any_req;
  logic grant;               // index of the requester that would be accepted now
  logic accept;
  logic fb;
  logic last_bit;

  // On contention the requester that was not served last wins; a lone
  // requester always wins. The granted requester is valid whenever any_req.
  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) && any_req && !grant;
  assign req1_ready = (state == IDLE) && any_req &&  grant;
  assign accept     = (state == IDLE) && any_req;

  assign fb       = shreg[DW-1] ^ crc[CW-1];
  assign last_bit = (cnt == CNTW'(DW - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      held  <= '0;
      crc   <= INIT;
      cnt   <= '0;
      last  <= 1'b1;
      src_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= grant ? req1_data : req0_data;
            held  <= grant ? req1_data : req0_data;
            src_q <= grant;
            last  <= grant;
            crc   <= INIT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          // MSB-first LFSR division; with INIT=0 this yields M(x)*x^16 mod G(x).
          crc   <= {crc[CW-2:0], 1'b0} ^ (fb ? POLY : '0);
          shreg <= {shreg[DW-2:0], 1'b0};
          cnt   <= cnt + CNTW'(1);
        end
        default: begin
          // DONE: crc, held and src_q stay frozen until the output handshake.
        end
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign out_data  = {held, crc};
  assign out_src   = src_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_crc16_frame_sched.sv
module tb_crc16_frame_sched;

  localparam int          DW   = 34;
  localparam int          CW   = 16;
  localparam logic [15:0] POLY = 16'hBAAD;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          out_valid;
  logic [DW+CW-1:0] out_data;
  logic          out_src;
  logic          out_ready;
  logic          busy;

  crc16_frame_sched #(.DW(DW), .CW(CW), .POLY(POLY), .INIT(16'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: polynomial long division of {data, 16'b0} by x^16 + POLY.
  function automatic logic [15:0] ref_crc(input logic [DW-1:0] d);
    logic [DW+15:0] r;
    r = {d, 16'h0};
    for (int i = DW + 15; i >= 16; i--) begin
      if (r[i]) r[i -: 17] = r[i -: 17] ^ {1'b1, POLY};
    end
    return r[15:0];
  endfunction

  // Scoreboard: accepted words pushed at the accept edge, popped on output handshake.
  typedef struct {
    logic          src;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb[$];
  int  acc_cnt [2];
  int  emit_cnt[2];
  int  emitted = 0;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (req0_valid && req0_ready) begin
        sb.push_back('{1'b0, req0_data});
        acc_cnt[0]++;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{1'b1, req1_data});
        acc_cnt[1]++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", {63'd0, out_valid}, 64'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("sb_out_data", 64'(out_data), 64'({e.data, ref_crc(e.data)}));
          check("sb_out_src", 64'(out_src), 64'(e.src));
          emit_cnt[e.src]++;
          emitted++;
        end
      end
    end
  end

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_idle", {63'd0, busy}, 64'd0);
  endtask

  typedef struct {
    logic             src;
    logic [DW-1:0]    data;
    logic [DW+CW-1:0] exp;
    int               stall;
  } vec_t;
  vec_t vecs[3];

  initial begin
    int n;
    int acc;
    int t;
    int last_cyc;
    int s;
    logic [63:0] r;
    logic [DW+CW-1:0] held_data;

    vecs[0] = '{1'b0, 34'h0, 50'h0,     0};
    vecs[1] = '{1'b0, 34'h2, 50'h2CFF7, 10};
    vecs[2] = '{1'b1, 34'h1, 50'h1BAAD, 0};

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_src", {63'd0, out_src}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    #1;
    check("idle_no_ready", {62'd0, req1_ready, req0_ready}, 64'd0);

    // Directed single-word vectors.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      out_ready = (vecs[i].stall == 0);
      if (vecs[i].src) begin
        req1_valid = 1'b1; req1_data = vecs[i].data;
      end else begin
        req0_valid = 1'b1; req0_data = vecs[i].data;
      end
      #1;
      check("vec_ready", {62'd0, req1_ready, req0_ready}, vecs[i].src ? 64'd2 : 64'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("vec_busy_after_accept", {63'd0, busy}, 64'd1);
      wait_out(n);
      check("vec_latency", 64'(n), 64'd34);
      check("vec_out_data", 64'(out_data), 64'(vecs[i].exp));
      check("vec_out_src", {63'd0, out_src}, {63'd0, vecs[i].src});
      held_data = out_data;
      for (int k = 0; k < vecs[i].stall; k++) begin
        @(posedge clk); #1;
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_data", 64'(out_data), 64'(held_data));
        check("stall_busy", {63'd0, busy}, 64'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("post_hs_valid", {63'd0, out_valid}, 64'd0);
      check("post_hs_busy", {63'd0, busy}, 64'd0);
    end

    // Both requesters always valid: grants alternate 0,1,0,1, 36 cycles apart.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 34'h0AAAA5555;
    req1_valid = 1'b1; req1_data = 34'h123456789;
    acc = 0; t = 0; last_cyc = 0;
    while (acc < 4 && t < 400) begin
      @(negedge clk);
      s = (req0_valid && req0_ready) ? 0 : ((req1_valid && req1_ready) ? 1 : -1);
      @(posedge clk); #1;
      t++;
      if (s >= 0) begin
        check("alt_grant", 64'(s), 64'(acc % 2));
        if (acc > 0) check("alt_spacing", 64'(cyc - last_cyc), 64'd36);
        last_cyc = cyc;
        r = {$urandom(), $urandom()};
        if (s == 0) req0_data = r[DW-1:0];
        else        req1_data = r[DW-1:0];
        acc++;
      end
    end
    check("alt_accepts", 64'(acc), 64'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Reset in the middle of SHIFT discards the word.
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_data = 34'h5;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 34'h3;
    #1;
    check("shift_no_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    req0_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    req0_valid = 1'b1; req0_data = 34'h1;
    #1;
    check("postrst_ready", {63'd0, req0_ready}, 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_out(n);
    check("postrst_latency", 64'(n), 64'd34);
    check("postrst_data", 64'(out_data), 64'h1BAAD);
    wait_idle();
    check("postrst_sb_empty", 64'(sb.size()), 64'd0);

    // Random words with random backpressure and legal valid drops.
    acc_cnt[0] = 0; acc_cnt[1] = 0; emit_cnt[0] = 0; emit_cnt[1] = 0;
    emitted = 0;
    t = 0;
    while (emitted < 1000 && t < 60000) begin
      logic a0, a1;
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      t++;
      if (a0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 1) == 1);
        r = {$urandom(), $urandom()};
        req0_data = r[DW-1:0];
      end else if ($urandom_range(0, 15) == 0) begin
        req0_valid = 1'b0;
      end
      if (a1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 1) == 1);
        r = {$urandom(), $urandom()};
        req1_data = r[DW-1:0];
      end else if ($urandom_range(0, 15) == 0) begin
        req1_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 7) != 0);
    end
    check("rand_frames", 64'(emitted), 64'd1000);
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rand_cnt_src0", 64'(emit_cnt[0]), 64'(acc_cnt[0]));
    check("rand_cnt_src1", 64'(emit_cnt[1]), 64'(acc_cnt[1]));
    check("rand_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
